// File: rtl/key_matrix_scan_if.sv
// Keypad scanner signal bundle: row returns in, column drive and debounced key result out.
interface key_matrix_scan_if;
  logic [4:0] i_key_in;
  logic [3:0] o_key_out;
  logic [4:0] o_key_code;
  logic       o_key_valid;
  logic       o_key_held;

  modport slave (
    input  i_key_in,
    output o_key_out,
    output o_key_code,
    output o_key_valid,
    output o_key_held
  );

  modport master (
    output i_key_in,
    input  o_key_out,
    input  o_key_code,
    input  o_key_valid,
    input  o_key_held
  );
endinterface

// File: rtl/key_matrix_scan.sv
// 4x5 keypad scanner: one-hot column drive, per-slot row sampling, lowest-code frame
// reduction and a once-per-frame debounce FSM emitting one key code per press.
module key_matrix_scan #(
  parameter int SCAN_CYCLES    = 10000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input logic              i_clk,
  input logic              i_rst,
  key_matrix_scan_if.slave kif
);

  localparam int SLOT_W = $clog2(SCAN_CYCLES);
  localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_SCANS);

  // state   | meaning
  // IDLE    | no key seen
  // CHECK   | candidate seen, counting identical frames
  // PRESSED | key accepted and held
  // RELEASE | accepted key missing, counting frames before dropping it
  typedef enum logic [1:0] {IDLE, CHECK, PRESSED, RELEASE} state_e;

  state_e             state_q, state_d;
  logic [SLOT_W-1:0]  slot_q, slot_d;
  logic [1:0]         col_q, col_d;
  logic [3:0]         out_q, out_d;
  logic [4:0]         acc_q, acc_d;
  logic [4:0]         cand_q, cand_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         code_q, code_d;
  logic               valid_q, valid_d;
  logic               held_q, held_d;

  logic [4:0]         col_base;
  logic [4:0]         col_code;
  logic [4:0]         frame_code;
  logic [CNT_W-1:0]   cnt_inc;
  logic               sample;
  logic               eval;

  assign col_base = {1'b0, col_q, 2'b00} + {3'b000, col_q};
  assign sample   = (slot_q == SLOT_LAST);
  assign eval     = sample && (col_q == 2'd3);
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // Descending loop so the lowest pressed row overrides higher ones.
  always_comb begin
    col_code = '0;
    for (int r = 4; r >= 0; r--) begin
      if (kif.i_key_in[r]) col_code = col_base + 5'(r + 1);
    end
  end

  // Earlier columns always carry lower codes, so any code already accumulated wins.
  assign frame_code = (acc_q != 5'd0) ? acc_q : col_code;

  always_comb begin
    slot_d  = slot_q;
    col_d   = col_q;
    out_d   = out_q;
    acc_d   = acc_q;
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;

    if (sample) begin
      slot_d = '0;
      col_d  = col_q + 2'd1;
      out_d  = 4'b0001 << col_d;
      acc_d  = eval ? 5'd0 : frame_code;
    end else begin
      slot_d = slot_q + SLOT_W'(1);
    end

    if (eval) begin
      case (state_q)
        IDLE: begin
          if (frame_code != 5'd0) begin
            state_d = CHECK;
            cand_d  = frame_code;
            cnt_d   = CNT_W'(1);
          end
        end
        CHECK: begin
          if (frame_code == 5'd0) begin
            state_d = IDLE;
          end else if (frame_code == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_d = PRESSED;
              code_d  = cand_q;
              valid_d = 1'b1;
              held_d  = 1'b1;
            end
          end else begin
            cand_d = frame_code;
            cnt_d  = CNT_W'(1);
          end
        end
        PRESSED: begin
          if (frame_code != cand_q) begin
            state_d = RELEASE;
            cnt_d   = CNT_W'(1);
          end
        end
        RELEASE: begin
          if (frame_code == cand_q) begin
            state_d = PRESSED;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_DONE) begin
              state_d = IDLE;
              held_d  = 1'b0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      slot_q  <= '0;
      col_q   <= 2'd0;
      out_q   <= 4'b0001;
      acc_q   <= 5'd0;
      cand_q  <= 5'd0;
      cnt_q   <= '0;
      code_q  <= 5'd0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      col_q   <= col_d;
      out_q   <= out_d;
      acc_q   <= acc_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  assign kif.o_key_out   = out_q;
  assign kif.o_key_code  = code_q;
  assign kif.o_key_valid = valid_q;
  assign kif.o_key_held  = held_q;

endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan with a behavioural keypad (SCAN_CYCLES=4, DEBOUNCE_SCANS=3, 16-clock frames).
module tb_key_matrix_scan;
  localparam int FRAME = 16;
  localparam int NV    = 16;

  typedef struct {
    logic [19:0] keys;
    int          frames;
    bit          pulse;
    int          code;
    int          held;
  } vec_t;

  typedef struct {
    int code;
    int cyc;
  } pend_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [19:0] keys = '0;
  logic [4:0]  rows;
  int          cyc = 0;
  int          passed = 0;
  int          total = 0;
  pend_t       exp_q[$];
  vec_t        vt[NV];

  key_matrix_scan_if kif();

  key_matrix_scan #(.SCAN_CYCLES(4), .DEBOUNCE_SCANS(3)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .kif  (kif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  // Keypad: a pressed key shorts its driven column onto its row.
  always_comb begin
    rows = '0;
    for (int c = 0; c < 4; c++) begin
      if (kif.o_key_out[c]) rows = rows | keys[c*5 +: 5];
    end
  end
  assign kif.i_key_in = rows;

  function automatic logic [19:0] k(input int code);
    logic [19:0] one;
    one = 20'd1;
    return one << (code - 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(negedge clk) begin : monitor
    pend_t e;
    if (!rst && kif.o_key_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("valid_code", kif.o_key_code, e.code);
        chk("valid_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0]  = '{k(12),         3, 1'b1, 12, 1};
    vt[1]  = '{k(12),         2, 1'b0, 12, 1};
    vt[2]  = '{20'd0,         3, 1'b0, 12, 0};
    vt[3]  = '{k(13),         3, 1'b1, 13, 1};
    vt[4]  = '{20'd0,         3, 1'b0, 13, 0};
    vt[5]  = '{k(7),          2, 1'b0, 13, 0};
    vt[6]  = '{20'd0,         1, 1'b0, 13, 0};
    vt[7]  = '{k(7),          3, 1'b1,  7, 1};
    vt[8]  = '{20'd0,         3, 1'b0,  7, 0};
    vt[9]  = '{k(14) | k(8),  3, 1'b1,  8, 1};
    vt[10] = '{20'd0,         3, 1'b0,  8, 0};
    vt[11] = '{k(12),         3, 1'b1, 12, 1};
    vt[12] = '{k(12) | k(9),  2, 1'b0, 12, 1};
    vt[13] = '{k(9),          4, 1'b1,  9, 1};
    vt[14] = '{20'd0,         1, 1'b0,  9, 1};
    vt[15] = '{k(9),          2, 1'b0,  9, 1};

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;

    // No key: column rotation and quiet outputs over the first frame.
    for (int i = 0; i < FRAME; i++) begin
      chk("key_out_rotate", kif.o_key_out, 1 << ((i / 4) % 4));
      chk("idle_outputs", {kif.o_key_code, kif.o_key_valid, kif.o_key_held}, 0);
      @(negedge clk);
      #1;
    end

    for (int i = 0; i < NV; i++) begin
      keys = vt[i].keys;
      if (vt[i].pulse) exp_q.push_back('{code: vt[i].code, cyc: cyc + vt[i].frames * FRAME});
      repeat (vt[i].frames * FRAME) @(negedge clk);
      #1;
      chk($sformatf("row%0d_code", i), kif.o_key_code, vt[i].code);
      chk($sformatf("row%0d_held", i), kif.o_key_held, vt[i].held);
      chk($sformatf("row%0d_pending", i), exp_q.size(), 0);
      exp_q.delete();
    end

    // Reset while key 9 is accepted and held, then re-acceptance from reset release.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_key_out", kif.o_key_out, 1);
    chk("rst_code", kif.o_key_code, 0);
    chk("rst_valid", kif.o_key_valid, 0);
    chk("rst_held", kif.o_key_held, 0);
    exp_q.push_back('{code: 9, cyc: 3 * FRAME});
    repeat (3 * FRAME) @(negedge clk);
    #1;
    chk("reaccept_code", kif.o_key_code, 9);
    chk("reaccept_held", kif.o_key_held, 1);
    chk("reaccept_pending", exp_q.size(), 0);

    keys = '0;
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/key_matrix_scan.md
Name: key_matrix_scan

Overview:
- Synthesizable scanner that initiates the keypad matrix protocol: drives one column at a time on o_key_out and samples the row returns on i_key_in.
- Debounces the result and delivers a single key code per press to the timer control logic.
- Sits between the board keypad pins (or the key_pad behavioural model in simulation) and the timer FSM; replaces ad-hoc scanning inside timer_top.

Parameters:
- SCAN_CYCLES, 10000, clocks each column is driven (1 ms at 10 MHz); minimum 2.
- DEBOUNCE_SCANS, 4, consecutive identical frames required to accept a press or a release; minimum 2.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  synchronous reset, active-high
- i_key_in  input  5  row returns, active-high; bit r=1 when the key at (driven column, row r) is pressed
- o_key_out  output  4  column drive, one-hot, active-high
- o_key_code  output  5  last accepted key code, 1..20; 0 until the first press
- o_key_valid  output  1  one-cycle pulse when a new press is accepted
- o_key_held  output  1  high while the accepted key remains debounced-pressed

Behaviour:
- Reset (i_rst sampled high at the clock edge): o_key_out=4'b0001, o_key_code=0, o_key_valid=0, o_key_held=0; column index, slot counter, frame accumulator and debounce state all cleared; FSM=IDLE. Reset mid-scan or mid-press aborts immediately; there is no valid pulse on reset exit.
- Column slot: slot counter runs 0..SCAN_CYCLES-1; column index c increments 0→1→2→3→0 when the counter wraps. o_key_out=1<<c is registered and changes on the same edge the index changes.
- Sampling: i_key_in is sampled only on the last cycle of each slot (counter==SCAN_CYCLES-1); earlier cycles are settle time.
- Code mapping: code = c*5 + r + 1 for row r (0..4). Range is 1..20; 0 means no key.
- Frame: 4 slots = 4*SCAN_CYCLES clocks. frame_code is the lowest code detected in the frame, or 0 if none. With multiple keys pressed, the lowest code wins.
- Debounce FSM is evaluated once per frame, on the last cycle of column 3. cand is a 5-bit register; cnt is a counter.
  - IDLE: frame_code!=0 → CHECK, cand=frame_code, cnt=1.
  - CHECK: frame_code==cand → cnt++; when cnt reaches DEBOUNCE_SCANS → PRESSED, o_key_code=cand, o_key_valid=1 for exactly one cycle (the cycle after the evaluation edge), o_key_held=1.
  - CHECK: frame_code==0 → IDLE.
  - CHECK: frame_code is another nonzero code → cand=frame_code, cnt=1.
  - PRESSED: frame_code==cand → stay. Anything else (0 or a different key) → RELEASE, cnt=1.
  - RELEASE: frame_code==cand → PRESSED (bounce); no new valid pulse.
  - RELEASE: otherwise cnt++; when cnt reaches DEBOUNCE_SCANS → IDLE, o_key_held=0.
- o_key_code holds its last value through release and IDLE; it changes only on acceptance.
- A new key pressed while another is held needs a full release, then a fresh debounce. No auto-repeat.
- Latency: a key stable before frame k starts raises o_key_valid one clock after the evaluation edge of frame k+DEBOUNCE_SCANS-1.
- Counter widths: slot counter $clog2(SCAN_CYCLES); cnt $clog2(DEBOUNCE_SCANS+1).

Test Plan:
- All cases use SCAN_CYCLES=4, DEBOUNCE_SCANS=3, key_pad model attached; frame = 16 clocks.
- Reset → o_key_out=0001 and rotates 0001,0010,0100,1000 every 4 clocks; code, valid and held stay 0 with no key.
- Hold key at column 2, row 1 (code 12) from reset release → one valid pulse at clock 48 after reset release, code=12, held=1; no further pulses while held.
- Release key 12 → held drops after 3 frames of no key; code stays 12. Press code 13 → valid, code=13.
- Bounce: key 7 for 2 frames, off 1 frame, on 3 frames → exactly one valid (code 7), asserted after the final 3 stable frames.
- Keys 14 and 8 held together → code=8. Key 9 pressed while 12 is held → no pulse until 12 is released and 9 is debounced.
- Assert i_rst during PRESSED → all outputs 0, o_key_out=0001 next cycle; the still-held key is re-accepted after 3 frames with one valid pulse.
